// File: rtl/weight_bias_loader_if.sv
// Word stream from the AXI side into the weight/bias loader.
// The source (master) drives data/valid, the loader (slave) drives ready.
interface weight_bias_loader_if #(
  parameter int dataWidth = 16
);
  logic [dataWidth-1:0] s_data;
  logic                 s_valid;
  logic                 s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/weight_bias_loader.sv
// Configuration master for one ELM layer: turns a flat word stream into the
// per-neuron broadcast of numWeight weights followed by one bias word,
// in ascending neuron order. All outputs are registered.
module weight_bias_loader #(
  parameter int dataWidth  = 16,
  parameter int numWeight  = 128,
  parameter int numNeurons = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [2*dataWidth:0]     layer_sel,
  weight_bias_loader_if.slave      s_bus,
  output logic [dataWidth-1:0]     weightValue,
  output logic                     weightValid,
  output logic [dataWidth-1:0]     biasValue,
  output logic                     biasValid,
  output logic [2*dataWidth:0]     config_layer_num,
  output logic [2*dataWidth:0]     config_neuron_num,
  output logic                     busy,
  output logic                     done
);

  localparam int CFG_W = 2*dataWidth + 1;
  localparam int WC_W  = $clog2(numWeight) + 1;
  localparam int NC_W  = (numNeurons > 1) ? $clog2(numNeurons) : 1;

  localparam logic [WC_W-1:0] W_LAST = WC_W'(numWeight - 1);
  localparam logic [NC_W-1:0] N_LAST = NC_W'(numNeurons - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WEIGHT,
    S_BIAS,
    S_DONE
  } state_t;

  state_t          state;
  logic [WC_W-1:0] w_cnt;
  logic [NC_W-1:0] n_cnt;
  logic            beat;

  // A word moves only when the loader is ready and the source offers one.
  assign beat = s_bus.s_valid & s_bus.s_ready;

  // Load sequencer: state, counters and every registered output.
  // NOTE: state is updated with non-blocking assignments so every branch sees
  // the pre-edge values of state and counters, exactly like the hardware.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= S_IDLE;
      w_cnt             <= '0;
      n_cnt             <= '0;
      s_bus.s_ready     <= 1'b0;
      weightValue       <= '0;
      weightValid       <= 1'b0;
      biasValue         <= '0;
      biasValid         <= 1'b0;
      config_layer_num  <= '0;
      config_neuron_num <= '0;
      busy              <= 1'b0;
      done              <= 1'b0;
    end else begin
      // Strobes last exactly one cycle unless re-asserted below.
      weightValid <= 1'b0;
      biasValid   <= 1'b0;
      done        <= 1'b0;
      // Lags n_cnt by one cycle so it still names the current neuron while
      // that neuron's bias strobe is on the bus.
      config_neuron_num <= CFG_W'(n_cnt);

      case (state)
        S_IDLE: begin
          if (start) begin
            state             <= S_WEIGHT;
            s_bus.s_ready     <= 1'b1;
            busy              <= 1'b1;
            w_cnt             <= '0;
            n_cnt             <= '0;
            config_layer_num  <= layer_sel;
            config_neuron_num <= '0;
          end
        end

        S_WEIGHT: begin
          if (beat) begin
            weightValue <= s_bus.s_data;
            weightValid <= 1'b1;
            if (w_cnt == W_LAST) begin
              w_cnt <= '0;
              state <= S_BIAS;
            end else begin
              w_cnt <= w_cnt + 1'b1;
            end
          end
        end

        S_BIAS: begin
          if (beat) begin
            biasValue <= s_bus.s_data;
            biasValid <= 1'b1;
            if (n_cnt == N_LAST) begin
              state         <= S_DONE;
              s_bus.s_ready <= 1'b0;
              done          <= 1'b1;
            end else begin
              n_cnt <= n_cnt + 1'b1;
              state <= S_WEIGHT;
            end
          end
        end

        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state         <= S_IDLE;
          s_bus.s_ready <= 1'b0;
          busy          <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_weight_bias_loader.sv
// Self-checking bench for weight_bias_loader with a 4-weight, 2-neuron layer.
// Stimulus pushes expected strobes into a scoreboard; a negedge monitor pops
// and compares them against the broadcast outputs.
module tb_weight_bias_loader;

  localparam int DW    = 16;
  localparam int NW    = 4;
  localparam int NN    = 2;
  localparam int TOTAL = NN * (NW + 1);
  localparam int CW    = 2*DW + 1;

  logic          clk;
  logic          rst;
  logic          start;
  logic [CW-1:0] layer_sel;
  logic [DW-1:0] weightValue;
  logic          weightValid;
  logic [DW-1:0] biasValue;
  logic          biasValid;
  logic [CW-1:0] config_layer_num;
  logic [CW-1:0] config_neuron_num;
  logic          busy;
  logic          done;

  weight_bias_loader_if #(.dataWidth(DW)) s_bus ();

  weight_bias_loader #(
    .dataWidth (DW),
    .numWeight (NW),
    .numNeurons(NN)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .layer_sel        (layer_sel),
    .s_bus            (s_bus.slave),
    .weightValue      (weightValue),
    .weightValid      (weightValid),
    .biasValue        (biasValue),
    .biasValid        (biasValid),
    .config_layer_num (config_layer_num),
    .config_neuron_num(config_neuron_num),
    .busy             (busy),
    .done             (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard entry: what the next output strobe must look like.
  typedef struct {
    bit            is_bias;
    logic [DW-1:0] value;
    int            neuron;
    logic [CW-1:0] layer;
    bit            last;
  } exp_t;

  exp_t sb[$];

  int n_cmp = 0;
  int n_bad = 0;
  int strobes = 0;
  logic [CW-1:0] cur_layer;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (weightValid || biasValid) begin
      strobes++;
      check("wv_bv_exclusive", {63'd0, weightValid & biasValid}, 64'd0);
      if (sb.size() == 0) begin
        check("unexpected_strobe", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        check("strobe_kind", {63'd0, biasValid}, {63'd0, e.is_bias});
        check("strobe_value", 64'(e.is_bias ? biasValue : weightValue), 64'(e.value));
        check("neuron_num", 64'(config_neuron_num), 64'(e.neuron));
        check("layer_num", 64'(config_layer_num), 64'(e.layer));
        check("done_on_last", {63'd0, done}, {63'd0, e.last});
      end
    end else if (done) begin
      check("done_without_bias", 64'd1, 64'd0);
    end
  end

  // Drives one load. abort_after > 0 stops feeding after that many beats
  // and returns at once (used for the mid-load reset).
  task automatic run_load(input logic [CW-1:0] layer, input bit throttle,
                          input bit mid_start, input logic [DW-1:0] base,
                          input int abort_after, output int cycles);
    int idx   = 0;
    int guard = 0;
    bit tog   = 1'b0;
    bit v;
    exp_t e;
    @(negedge clk);
    start     = 1'b1;
    layer_sel = layer;
    cur_layer = layer;
    @(negedge clk);
    start     = 1'b0;
    layer_sel = '0;
    cycles    = 1;
    check("busy_after_start", {63'd0, busy}, 64'd1);
    check("ready_after_start", {63'd0, s_bus.s_ready}, 64'd1);
    while (idx < TOTAL && guard < 200 && !(abort_after > 0 && idx == abort_after)) begin
      v   = throttle ? tog : 1'b1;
      tog = ~tog;
      s_bus.s_valid = v;
      s_bus.s_data  = base + DW'(idx);
      start     = mid_start && (idx == 3);
      layer_sel = start ? CW'(3) : '0;
      if (v && s_bus.s_ready) begin
        e.is_bias = ((idx % (NW + 1)) == NW);
        e.value   = base + DW'(idx);
        e.neuron  = idx / (NW + 1);
        e.layer   = cur_layer;
        e.last    = (idx == TOTAL - 1);
        sb.push_back(e);
        idx++;
      end
      @(negedge clk);
      cycles++;
      guard++;
    end
    s_bus.s_valid = 1'b0;
    start         = 1'b0;
    layer_sel     = '0;
    if (guard >= 200) check("feed_timeout", 64'd1, 64'd0);
    if (abort_after == 0) begin
      guard = 0;
      while (busy && guard < 50) begin
        @(negedge clk);
        cycles++;
        guard++;
      end
      if (guard >= 50) check("idle_timeout", 64'd1, 64'd0);
    end
  endtask

  typedef struct {
    logic [CW-1:0] layer;
    bit            throttle;
    bit            mid_start;
    logic [DW-1:0] base;
    int            exp_cycles;
    logic [CW-1:0] exp_layer;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int cyc;
    vecs[0] = '{layer: CW'(1), throttle: 1'b0, mid_start: 1'b0, base: 16'd1,
                exp_cycles: 12, exp_layer: CW'(1)};
    vecs[1] = '{layer: CW'(1), throttle: 1'b1, mid_start: 1'b0, base: 16'd1,
                exp_cycles: 22, exp_layer: CW'(1)};
    vecs[2] = '{layer: CW'(1), throttle: 1'b0, mid_start: 1'b1, base: 16'd1,
                exp_cycles: 12, exp_layer: CW'(1)};
    vecs[3] = '{layer: 33'h1_0000_0002, throttle: 1'b1, mid_start: 1'b0, base: 16'hFFF8,
                exp_cycles: 22, exp_layer: 33'h1_0000_0002};

    rst           = 1'b1;
    start         = 1'b0;
    layer_sel     = '0;
    s_bus.s_valid = 1'b0;
    s_bus.s_data  = '0;
    cur_layer     = '0;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_ready", {63'd0, s_bus.s_ready}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_outputs", {weightValue, biasValue, 30'd0, weightValid, biasValid},
          64'd0);
    check("rst_layer", 64'(config_layer_num), 64'd0);
    check("rst_neuron", 64'(config_neuron_num), 64'd0);
    rst = 1'b0;

    // Idle input: an offered word is not consumed without start.
    s_bus.s_valid = 1'b1;
    s_bus.s_data  = 16'hDEAD;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("idle_ready", {63'd0, s_bus.s_ready}, 64'd0);
      check("idle_busy", {63'd0, busy}, 64'd0);
    end
    s_bus.s_valid = 1'b0;

    // Table-driven full loads.
    for (int i = 0; i < 4; i++) begin
      strobes = 0;
      run_load(vecs[i].layer, vecs[i].throttle, vecs[i].mid_start, vecs[i].base, 0, cyc);
      check($sformatf("v%0d_cycles", i), 64'(cyc), 64'(vecs[i].exp_cycles));
      check($sformatf("v%0d_strobes", i), 64'(strobes), 64'(TOTAL));
      check($sformatf("v%0d_sb_empty", i), 64'(sb.size()), 64'd0);
      check($sformatf("v%0d_layer", i), 64'(config_layer_num), 64'(vecs[i].exp_layer));
      check($sformatf("v%0d_ready_idle", i), {63'd0, s_bus.s_ready}, 64'd0);
    end

    // Reset mid-load after 6 accepted beats, asserted between edges.
    run_load(CW'(1), 1'b0, 1'b0, 16'd50, 6, cyc);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_ready", {63'd0, s_bus.s_ready}, 64'd0);
    check("async_rst_busy", {63'd0, busy}, 64'd0);
    check("async_rst_strobes", {62'd0, weightValid, biasValid}, 64'd0);
    check("async_rst_layer", 64'(config_layer_num), 64'd0);
    check("async_rst_sb_empty", 64'(sb.size()), 64'd0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    strobes = 0;
    run_load(CW'(2), 1'b0, 1'b0, 16'd100, 0, cyc);
    check("post_rst_cycles", 64'(cyc), 64'd12);
    check("post_rst_strobes", 64'(strobes), 64'(TOTAL));
    check("post_rst_sb_empty", 64'(sb.size()), 64'd0);

    repeat (3) @(negedge clk);
    check("final_sb_empty", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/weight_bias_loader.md
# weight_bias_loader

Streaming configuration master that feeds the neuron array of one ELM layer. It accepts a flat stream of fixed-point words from the AXI side with a valid/ready handshake. It re-emits them as the `weightValue`/`weightValid`, `biasValue`/`biasValid`, `config_layer_num` and `config_neuron_num` broadcast that every neuron decodes. Per neuron, in ascending neuron order, it sends exactly `numWeight` weights followed by one bias word.

## Interface
Parameters:
- dataWidth, 16, width of weight/bias words (matches `dataWidth` macro)
- numWeight, 128, weights per neuron
- numNeurons, 64, neurons in the target layer

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- start  in  1  single-cycle pulse that begins a load; honoured only in IDLE
- layer_sel  in  2*dataWidth+1  target layer number; sampled on accepted start
- s_data  in  dataWidth  incoming weight/bias word
- s_valid  in  1  s_data valid
- s_ready  out  1  loader accepts a word this cycle
- weightValue  out  dataWidth  registered weight word
- weightValid  out  1  one-cycle strobe per weight
- biasValue  out  dataWidth  registered bias word
- biasValid  out  1  one-cycle strobe per bias
- config_layer_num  out  2*dataWidth+1  latched layer_sel
- config_neuron_num  out  2*dataWidth+1  current neuron index, zero-extended
- busy  out  1  high whenever state is not IDLE
- done  out  1  one-cycle pulse at completion

## Operation
- States:
  - IDLE: s_ready=0.
  - WEIGHT: s_ready=1.
  - BIAS: s_ready=1.
  - DONE: s_ready=0.
- A beat is accepted when s_valid & s_ready.
- Downstream has no backpressure, so every accepted beat produces exactly one output strobe.
- IDLE -> WEIGHT on start. This latches layer_sel into config_layer_num and clears w_cnt and n_cnt. config_neuron_num becomes 0.
- In WEIGHT, each accepted beat:
  - Registers s_data into weightValue and pulses weightValid.
  - Increments w_cnt (width $clog2(numWeight)+1).
  - On the beat with w_cnt == numWeight-1: go to BIAS and clear w_cnt.
- In BIAS, the accepted beat:
  - Registers s_data into biasValue and pulses biasValid.
  - If n_cnt == numNeurons-1: go to DONE.
  - Otherwise: increment n_cnt and return to WEIGHT.
- config_neuron_num tracks n_cnt. It updates on the cycle after the bias strobe, so it is stable and correct on every weightValid/biasValid cycle for that neuron.
- DONE -> IDLE after one cycle. done=1 during DONE.
- start while busy is ignored.
- s_valid while s_ready=0 is not consumed; the word is held by the source.
- Neurons reset their write address only on rst. The loader therefore always delivers exactly numWeight weights per neuron, so neuron addresses wrap back to aligned.
- biasValid is broadcast. The layer wrapper gates it with config_neuron_num match; the loader guarantees config_neuron_num is valid during biasValid.
- Reset, including mid-load:
  - All outputs 0, state IDLE, counters 0, config_layer_num 0.
  - A partial load is abandoned; the next load requires a fresh start.

## Timing
- start at edge t: state WEIGHT and s_ready=1 from cycle t+1.
- Beat accepted at edge k: weightValid (or biasValid) =1 with data during cycle k+1, exactly one cycle. Latency is 1 cycle.
- Back-to-back accepted beats give back-to-back strobes.
- Gaps in s_valid give gaps in strobes with no state change.
- Last weight of a neuron accepted at edge k: s_ready stays 1 in cycle k+1 (BIAS). No bubble.
- Last bias accepted at edge k:
  - Cycle k+1: biasValid=1, done=1, busy=1, s_ready=0.
  - Cycle k+2: IDLE, busy=0.
- Minimum full-load time from start: 1 + numNeurons*(numWeight+1) + 1 cycles.
- weightValid and biasValid are never high in the same cycle.

## Test plan
- Reset: assert rst asynchronously between edges -> all outputs 0 immediately; s_ready=0 while rst high.
- Full load: numWeight=4, numNeurons=2, layer_sel=1, s_valid held 1, data 1..10 -> weights 1-4 with neuron 0, bias 5 with neuron 0, weights 6-9 with neuron 1, bias 10 with neuron 1; done in the same cycle as bias 10; total 12 cycles from start.
- Throttled source: s_valid toggles every other cycle -> same 10 strobes in the same order; none duplicated or lost; done only after bias 10.
- Start while busy: pulse start mid-load with layer_sel=3 -> config_layer_num stays 1; sequence unaffected.
- Reset mid-operation: rst after 6 accepted beats, then start and 10 fresh words -> output restarts at neuron 0, weight 0; no stale strobes.
- Idle input: s_valid=1 in IDLE without start -> s_ready=0; no strobes; the word is consumed only after start.
